// File: rtl/layer1_accumulator.sv
// layer1_accumulator: multiply-accumulates unsigned samples against per-node signed weights and emits saturated packed sums.
// Latency: sum_out/trigger appear the cycle after a frame's last accepted beat (EMIT); NUM_INPUTS+1 cycles per frame.
// Backpressure: in_ready is low during reset and for the EMIT cycle. Optional LAYER1_BIAS_EN adds a per-node bias input.
module layer1_accumulator #(
  parameter int NODES      = 2,
  parameter int OUT_W      = 8,
  parameter int IN_W       = 4,
  parameter int W_W        = 4,
  parameter int NUM_INPUTS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
`ifdef LAYER1_BIAS_EN
  input  logic [NODES*OUT_W-1:0] bias,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic [NODES*W_W-1:0]   weights,
  output logic [NODES*OUT_W-1:0] sum_out,
  output logic                   trigger,
  output logic                   frame_busy
);

  localparam int CNT_W = $clog2(NUM_INPUTS);
  localparam int ACC_W = IN_W + W_W + 1 + CNT_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc  [NODES];
  logic signed [ACC_W-1:0] prod [NODES];
  logic signed [ACC_W-1:0] init [NODES];
  logic [NODES*OUT_W-1:0]  sat_bus;
  logic [NODES*OUT_W-1:0]  sum_q;
  logic                    accept;
  logic                    emit_ok;

  function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (a < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return a[OUT_W-1:0];
  endfunction

  // Operands are widened to ACC_W before multiplying so the product is exact.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      prod[n] = $signed({{(ACC_W-IN_W){1'b0}}, in_data})
              * $signed({{(ACC_W-W_W){weights[n*W_W+W_W-1]}}, weights[n*W_W +: W_W]});
`ifdef LAYER1_BIAS_EN
      init[n] = {{(ACC_W-OUT_W){bias[n*OUT_W+OUT_W-1]}}, bias[n*OUT_W +: OUT_W]};
`else
      init[n] = '0;
`endif
    end
  end

  always_comb begin
    sat_bus = '0;
    for (int n = 0; n < NODES; n++) begin
      sat_bus[n*OUT_W +: OUT_W] = sat(acc[n]);
    end
  end

  // A clear or reset during EMIT suppresses the pulse and leaves the held sums visible.
  assign emit_ok    = (state == EMIT) && !clear && !reset;
  assign trigger    = emit_ok;
  assign sum_out    = emit_ok ? sat_bus : sum_q;
  assign in_ready   = (state == ACCUM) && !reset;
  assign frame_busy = (state == ACCUM) && (cnt != '0);
  assign accept     = in_valid && in_ready && !clear;

  always_ff @(posedge clk) begin
    if (reset || clear || state == EMIT) begin
      state <= ACCUM;
      cnt   <= '0;
      for (int n = 0; n < NODES; n++) acc[n] <= init[n];
    end else if (accept) begin
      for (int n = 0; n < NODES; n++) acc[n] <= acc[n] + prod[n];
      if (cnt == LAST_CNT) state <= EMIT;
      else                 cnt   <= cnt + 1'b1;
    end

    if (reset)        sum_q <= '0;
    else if (emit_ok) sum_q <= sat_bus;
  end

endmodule

// File: tb/tb_layer1_accumulator.sv
// Directed bench for layer1_accumulator with NUM_INPUTS=4, two nodes, 8-bit outputs.
module tb_layer1_accumulator;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_ready, trigger, frame_busy;
  logic [3:0]  in_data;
  logic [7:0]  weights;
  logic [15:0] sum_out;
`ifdef LAYER1_BIAS_EN
  logic [15:0] bias;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  layer1_accumulator #(
    .NODES(2), .OUT_W(8), .IN_W(4), .W_W(4), .NUM_INPUTS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
`ifdef LAYER1_BIAS_EN
    .bias(bias),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .weights(weights),
    .sum_out(sum_out),
    .trigger(trigger),
    .frame_busy(frame_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [3:0] d, input logic [7:0] w);
    in_valid = v;
    in_data  = d;
    weights  = w;
    tick();
  endtask

  // Four back-to-back beats 1,2,3,4; returns sitting in the EMIT cycle.
  task automatic frame_1234(input string tag);
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 4'(i + 1), 8'hF1);
      if (i < 3) check({tag, "_notrig"}, trigger, 0);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; weights = '0;
`ifdef LAYER1_BIAS_EN
    bias = '0;
`endif
    tick();
    tick();
    check("rst_sum", sum_out, 0);
    check("rst_trig", trigger, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_busy", frame_busy, 0);
    reset = 1'b0;
    #1;
    check("rst_rdy_after", in_ready, 1);

    // Held-valid frame, +1/-1 weights.
    frame_1234("t1");
    check("t1_trig", trigger, 1);
    check("t1_sum", sum_out, 16'hF60A);
    check("t1_rdy_emit", in_ready, 0);
    check("t1_busy_emit", frame_busy, 0);
    beat(1'b1, 4'd9, 8'hF1);
    in_valid = 1'b0;
    check("t1_trig_once", trigger, 0);
    check("t1_hold", sum_out, 16'hF60A);
    check("t1_emit_beat_ignored", frame_busy, 0);
    check("t1_rdy_back", in_ready, 1);

    // Saturation both ways: 420 -> 127, -480 -> -128.
    for (int i = 0; i < 4; i++) beat(1'b1, 4'd15, 8'h87);
    check("t2_trig", trigger, 1);
    check("t2_sum", sum_out, 16'h807F);
    beat(1'b0, 4'd0, 8'h00);

    // Alternating valid: idle cycles must not count.
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 4'(i + 1), 8'hF1);
      if (i < 3) begin
        check("t3_notrig_beat", trigger, 0);
        beat(1'b0, 4'hF, 8'h77);
        check("t3_notrig_idle", trigger, 0);
        check("t3_busy", frame_busy, 1);
      end
    end
    check("t3_trig", trigger, 1);
    check("t3_sum", sum_out, 16'hF60A);
    beat(1'b0, 4'd0, 8'h00);

    // Clear mid-frame, beat in the clear cycle dropped.
    beat(1'b1, 4'd5, 8'h11);
    beat(1'b1, 4'd5, 8'h11);
    check("t4_busy", frame_busy, 1);
    clear = 1'b1;
    beat(1'b1, 4'd7, 8'h11);
    clear = 1'b0;
    check("t4_busy_cleared", frame_busy, 0);
    check("t4_sum_held", sum_out, 16'hF60A);
    check("t4_trig_cleared", trigger, 0);
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 4'd2, 8'h13);
      if (i < 3) check("t4_notrig", trigger, 0);
    end
    check("t4_trig", trigger, 1);
    check("t4_sum", sum_out, 16'h0818);
    beat(1'b0, 4'd0, 8'h00);

    // Clear during EMIT: no pulse, no update.
    frame_1234("t5");
    in_valid = 1'b0;
    clear = 1'b1;
    #1;
    check("t5_trig_suppressed", trigger, 0);
    check("t5_sum_emit", sum_out, 16'h0818);
    tick();
    clear = 1'b0;
    #1;
    check("t5_sum_after", sum_out, 16'h0818);
    check("t5_busy", frame_busy, 0);
    check("t5_trig_after", trigger, 0);

    // Reset mid-frame.
    beat(1'b1, 4'd3, 8'h11);
    beat(1'b1, 4'd3, 8'h11);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_trig_rst", trigger, 0);
    tick();
    check("t6_sum_rst", sum_out, 0);
    check("t6_busy_rst", frame_busy, 0);
    check("t6_rdy_rst", in_ready, 0);
    reset = 1'b0;
    #1;
    check("t6_rdy_after", in_ready, 1);
    frame_1234("t6");
    check("t6_trig", trigger, 1);
    check("t6_sum", sum_out, 16'hF60A);

    // Reset during EMIT.
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("t7_trig_rst", trigger, 0);
    tick();
    check("t7_sum_rst", sum_out, 0);
    reset = 1'b0;
    #1;
    check("t7_rdy_after", in_ready, 1);
    check("t7_trig_after", trigger, 0);

`ifdef LAYER1_BIAS_EN
    bias  = 16'h05FB;
    clear = 1'b1;
    beat(1'b0, 4'd0, 8'h00);
    clear = 1'b0;
    frame_1234("t8");
    check("t8_trig", trigger, 1);
    check("t8_bias_sum", sum_out, 16'hFB05);
    beat(1'b0, 4'd0, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
